// File: rtl/bus8_pkg.sv
// Shared types and constants for the two-port 8-bit register bus master arbiter.
package bus8_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  typedef logic req_idx_t;

endpackage

// File: rtl/bus8_rr_arb2.sv
// Combinational two-way round-robin grant: on contention the requester not granted last wins.
module bus8_rr_arb2
  import bus8_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_gnt,
  output logic [1:0] gnt,
  output req_idx_t   gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_gnt;
      gnt     = last_gnt ? 2'b01 : 2'b10;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
      gnt     = 2'b10;
    end else if (req[0]) begin
      gnt_idx = 1'b0;
      gnt     = 2'b01;
    end
  end

endmodule

// File: rtl/bus8_master_arb_x2.sv
// Two-requester master for the 8-bit register bus: round-robin grant, one-cycle CS,
// read wait with timeout, and a registered per-requester acknowledge.
module bus8_master_arb_x2
  import bus8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic       i_Bus_Rst_L,
  input  logic       i_Bus_Clk,
  input  logic       i_M0_Req,
  input  logic       i_M0_Wr_Rd_n,
  input  logic [7:0] i_M0_Addr,
  input  logic [7:0] i_M0_Wr_Data,
  output logic       o_M0_Ack,
  output logic [7:0] o_M0_Rd_Data,
  output logic       o_M0_Err,
  input  logic       i_M1_Req,
  input  logic       i_M1_Wr_Rd_n,
  input  logic [7:0] i_M1_Addr,
  input  logic [7:0] i_M1_Wr_Data,
  output logic       o_M1_Ack,
  output logic [7:0] o_M1_Rd_Data,
  output logic       o_M1_Err,
  output logic       o_Bus_CS,
  output logic       o_Bus_Wr_Rd_n,
  output logic [7:0] o_Bus_Addr8,
  output logic [7:0] o_Bus_Wr_Data,
  input  logic [7:0] i_Bus_Rd_Data,
  input  logic       i_Bus_Rd_DV
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t          state, state_nx;
  logic [7:0]      cnt, cnt_nx;
  req_idx_t        last_gnt, last_gnt_nx;
  req_idx_t        cur, cur_nx;
  logic [1:0]      arb_gnt;
  req_idx_t        arb_idx;
  logic            cs, cs_nx;
  logic            wr_rd_n, wr_rd_n_nx;
  logic [7:0]      addr, addr_nx;
  logic [7:0]      wdata, wdata_nx;
  logic [1:0]      ack, ack_nx;
  logic [1:0]      err, err_nx;
  logic [1:0][7:0] rd_data, rd_data_nx;

  bus8_rr_arb2 u_arb (
    .req      ({i_M1_Req, i_M0_Req}),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // Every output is computed one cycle ahead so that all outputs come straight from flops.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_gnt_nx = last_gnt;
    cur_nx      = cur;
    cs_nx       = 1'b0;
    wr_rd_n_nx  = wr_rd_n;
    addr_nx     = addr;
    wdata_nx    = wdata;
    ack_nx      = 2'b00;
    err_nx      = 2'b00;
    rd_data_nx  = '0;
    case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          cur_nx     = arb_idx;
          wr_rd_n_nx = arb_idx ? i_M1_Wr_Rd_n : i_M0_Wr_Rd_n;
          addr_nx    = arb_idx ? i_M1_Addr    : i_M0_Addr;
          wdata_nx   = arb_idx ? i_M1_Wr_Data : i_M0_Wr_Data;
          cs_nx      = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_rd_n) begin
          ack_nx[cur] = 1'b1;
          state_nx    = DONE;
        end else begin
          cnt_nx   = '0;
          state_nx = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // Data valid wins over a timeout landing in the same cycle.
        if (i_Bus_Rd_DV) begin
          ack_nx[cur]     = 1'b1;
          rd_data_nx[cur] = i_Bus_Rd_Data;
          state_nx        = DONE;
        end else if (cnt == TO_LIMIT) begin
          ack_nx[cur]     = 1'b1;
          rd_data_nx[cur] = ERR_DATA;
          err_nx[cur]     = 1'b1;
          state_nx        = DONE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DONE: begin
        last_gnt_nx = cur;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      cur      <= 1'b0;
      cs       <= 1'b0;
      wr_rd_n  <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      ack      <= '0;
      err      <= '0;
      rd_data  <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last_gnt <= last_gnt_nx;
      cur      <= cur_nx;
      cs       <= cs_nx;
      wr_rd_n  <= wr_rd_n_nx;
      addr     <= addr_nx;
      wdata    <= wdata_nx;
      ack      <= ack_nx;
      err      <= err_nx;
      rd_data  <= rd_data_nx;
    end
  end

  assign o_Bus_CS      = cs;
  assign o_Bus_Wr_Rd_n = wr_rd_n;
  assign o_Bus_Addr8   = addr;
  assign o_Bus_Wr_Data = wdata;
  assign o_M0_Ack      = ack[0];
  assign o_M0_Err      = err[0];
  assign o_M0_Rd_Data  = rd_data[0];
  assign o_M1_Ack      = ack[1];
  assign o_M1_Err      = err[1];
  assign o_M1_Rd_Data  = rd_data[1];

endmodule

// File: doc/bus8_master_arb_x2.md
# bus8_master_arb_x2

Two-port master arbiter and sequencer for the 8-bit FPGA register bus. It accepts whole read or write transactions from two independent requesters, such as a UART command decoder and an on-chip sequencer. It grants one requester at a time in round-robin order and drives the single-cycle chip-select protocol to the downstream register slaves. Each transaction completes with an acknowledge, read data, and a timeout error flag. It sits between the masters and the address decoder that fans CS out to the register banks.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: cycles spent waiting for i_Bus_Rd_DV before a read is aborted. Legal range 1..255.
- ERR_DATA, 8'hFF: read data returned on timeout.

Ports:
- i_Bus_Rst_L  in  1  reset, asynchronous, active-low
- i_Bus_Clk  in  1  clock
- i_M0_Req  in  1  requester 0 transaction request; level, held until ack
- i_M0_Wr_Rd_n  in  1  1 = write, 0 = read
- i_M0_Addr  in  8  target address
- i_M0_Wr_Data  in  8  write data
- o_M0_Ack  out  1  one-cycle completion pulse
- o_M0_Rd_Data  out  8  read data, valid while o_M0_Ack = 1
- o_M0_Err  out  1  read timeout, valid while o_M0_Ack = 1
- i_M1_* / o_M1_*: identical set for requester 1
- o_Bus_CS  out  1  one-cycle chip-select pulse to slaves
- o_Bus_Wr_Rd_n  out  1  direction to slaves
- o_Bus_Addr8  out  8  address to slaves
- o_Bus_Wr_Data  out  8  write data to slaves
- i_Bus_Rd_Data  in  8  read data from slaves
- i_Bus_Rd_DV  in  1  read data valid from slaves; registered, one cycle after CS

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE
  - If any Req is high, choose the winner, latch its Wr_Rd_n, Addr and Wr_Data into bus registers, and go to ISSUE.
  - Arbitration: a single request wins. With simultaneous requests, the requester not granted last wins.
  - The last-grant pointer resets to 1, so M0 wins the first contention.
- ISSUE
  - o_Bus_CS = 1 for exactly one cycle.
  - Write: go to DONE.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD
  - When i_Bus_Rd_DV = 1, capture i_Bus_Rd_Data, set err = 0, and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, load ERR_DATA, set err = 1, and go to DONE.
  - A DV arriving in the same cycle the counter reaches the limit takes priority over the timeout.
- DONE
  - Pulse Ack of the granted requester for one cycle, with Rd_Data and Err presented.
  - Update the last-grant pointer and return to IDLE.
  - Writes always report Err = 0 and Rd_Data = 0.
- Requester rule: Req, Wr_Rd_n, Addr and Wr_Data must stay stable from Req rise through Ack. Req must be low in the cycle after Ack. If Req is still high then, it is taken as a new request.
- If Req drops before Ack, the transaction still completes and Ack is still pulsed.
- i_Bus_Rd_DV outside WAIT_RD is ignored.
- The non-granted requester's Ack, Rd_Data and Err stay 0.
- o_Bus_Addr8, o_Bus_Wr_Data and o_Bus_Wr_Rd_n hold their values until the next grant.

## Timing
- Reset: all outputs 0, FSM = IDLE, counter = 0, last-grant pointer = 1.
- Reset asserted mid-transaction aborts it immediately. No Ack is issued, and CS drops asynchronously.
- Write: Req sampled in IDLE at cycle 0 → CS in cycle 1 → Ack in cycle 2. Latency is 2 cycles.
- Read with a standard slave: Req at cycle 0 → CS in cycle 1 → DV in cycle 2 → Ack with data in cycle 3.
- Read timeout: Ack with Err in cycle 2 + TIMEOUT_CYCLES + 1.
- Back-to-back: the earliest next CS is 2 cycles after the previous Ack (DONE → IDLE → ISSUE).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package bus8_pkg:
  - state enum (IDLE, ISSUE, WAIT_RD, DONE)
  - ERR_DATA default constant
  - requester index type (1 bit)
- Sub-module bus8_rr_arb2:
  - combinational two-way round-robin grant from the two Req inputs and the last-grant pointer
  - outputs a one-hot grant and a grant index
- Top level: FSM, counter, bus registers, per-requester output registers.

## Test plan
- Single write: M0 writes 0x5A to address 0x03 → one CS cycle with o_Bus_Addr8 = 0x03, o_Bus_Wr_Data = 0x5A, Wr_Rd_n = 1 → o_M0_Ack 2 cycles after Req, Err = 0, o_M1_Ack never pulses.
- Single read: M1 reads address 0x10 while the slave model returns 0xC3 one cycle after CS → o_M1_Ack in cycle 3 with Rd_Data = 0xC3 and Err = 0.
- Contention: M0 and M1 request in the same cycle, repeatedly, for 4 transactions → grants alternate M0, M1, M0, M1. Exactly one CS per transaction, and no CS overlap.
- Timeout: read to a silent slave with TIMEOUT_CYCLES = 15 → Ack 18 cycles after Req with Rd_Data = 0xFF and Err = 1. A subsequent normal read succeeds.
- DV and timeout in the same cycle: DV is injected on the last timeout cycle → Err = 0 and the slave data is returned.
- Reset mid-read: assert i_Bus_Rst_L low during WAIT_RD → all outputs 0 and no Ack. After release, M0 wins the first contention.
